// File: rtl/vram_frame_player.sv
// Multi-frame video RAM with a vsync-driven animation sequencer (hold / loop / ping-pong / one-shot).
// Optional frame_tick output is enabled by defining VRAM_FRAME_TICK_EN.
module vram_frame_player #(
    parameter int ADDR_W     = 14,
    parameter int COLOR_W    = 1,
    parameter int NUM_FRAMES = 4,
    parameter int FRAME_W    = 2,
    parameter int HOLD_W     = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [ADDR_W-1:0]      address,
    input  logic                   vsync,
    input  logic                   we,
    input  logic [FRAME_W-1:0]     wr_frame,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [3*COLOR_W-1:0]   wr_data,
    input  logic [1:0]             mode,
    input  logic [HOLD_W-1:0]      hold_frames,
    input  logic [FRAME_W-1:0]     sel_frame,
    input  logic                   start,
    output logic [COLOR_W-1:0]     red,
    output logic [COLOR_W-1:0]     green,
    output logic [COLOR_W-1:0]     blue,
    output logic [FRAME_W-1:0]     cur_frame,
    output logic                   done,
`ifdef VRAM_FRAME_TICK_EN
    output logic                   frame_tick,
`endif
    output logic [1:0]             dbg_state
);

    localparam int PIX_W = 3 * COLOR_W;
    localparam int DEPTH = NUM_FRAMES << ADDR_W;
    localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(NUM_FRAMES - 1);
    localparam logic [ADDR_W-1:0]  BLANK_ADDR = '1;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_LOOP = 2'b01;
    localparam logic [1:0] MODE_PING = 2'b10;
    localparam logic [1:0] MODE_ONCE = 2'b11;

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [FRAME_W-1:0]   r_cur_frame;
    logic [HOLD_W-1:0]    r_hold_cnt;
    logic                 r_dir;
    logic                 r_start_pend;
    logic                 r_done;

    state_t               w_state_nxt;
    logic [FRAME_W-1:0]   w_cur_nxt;
    logic [HOLD_W-1:0]    w_hold_nxt;
    logic                 w_dir_nxt;
    logic                 w_pend_nxt;
    logic                 w_done_nxt;

    logic [FRAME_W-1:0]   w_step_frame;
    logic                 w_step_dir;
    logic                 w_step_last;
    logic [HOLD_W:0]      w_hold_inc;
    logic [HOLD_W:0]      w_hold_lim;
    logic [FRAME_W-1:0]   w_sel_clamped;
    logic                 w_wr_ok;

    logic [PIX_W-1:0]     r_mem [DEPTH];
    logic [PIX_W-1:0]     r_mem_q;
    logic [PIX_W-1:0]     r_data;
    logic [PIX_W-1:0]     r_rgb;
    logic                 r_blank0;
    logic                 r_blank1;

    // ------------------------------------------------------------------
    // Pixel storage: write port plus read-first synchronous read port.
    // The read uses the frame displayed when the address is sampled, so
    // pixels in flight finish with the old frame.
    // ------------------------------------------------------------------
    assign w_wr_ok = we && (wr_frame <= LAST_FRAME);

    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[{wr_frame, wr_addr}] <= wr_data;
        end
        r_mem_q <= r_mem[{r_cur_frame, address}];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_blank0 <= 1'b0;
            r_blank1 <= 1'b0;
            r_data   <= '0;
            r_rgb    <= '0;
        end else begin
            r_blank0 <= (address == BLANK_ADDR);
            r_blank1 <= r_blank0;
            r_data   <= r_mem_q;
            r_rgb    <= r_blank1 ? '0 : r_data;
        end
    end

    assign red   = r_rgb[PIX_W-1 -: COLOR_W];
    assign green = r_rgb[2*COLOR_W-1 -: COLOR_W];
    assign blue  = r_rgb[COLOR_W-1:0];

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    assign w_sel_clamped = (sel_frame > LAST_FRAME) ? LAST_FRAME : sel_frame;
    assign w_hold_inc    = {1'b0, r_hold_cnt} + 1'b1;
    assign w_hold_lim    = (hold_frames == '0) ? (HOLD_W+1)'(1) : {1'b0, hold_frames};

    // Candidate next frame for the current mode, evaluated every cycle so a
    // mode change while running is picked up at the next step.
    always_comb begin
        w_step_frame = r_cur_frame;
        w_step_dir   = r_dir;
        w_step_last  = 1'b0;
        case (mode)
            MODE_LOOP: begin
                w_step_frame = (r_cur_frame == LAST_FRAME) ? '0 : r_cur_frame + 1'b1;
            end
            MODE_PING: begin
                if (r_dir) begin
                    if (r_cur_frame == LAST_FRAME) begin
                        w_step_frame = r_cur_frame - 1'b1;
                        w_step_dir   = 1'b0;
                    end else begin
                        w_step_frame = r_cur_frame + 1'b1;
                    end
                end else begin
                    if (r_cur_frame == '0) begin
                        w_step_frame = r_cur_frame + 1'b1;
                        w_step_dir   = 1'b1;
                    end else begin
                        w_step_frame = r_cur_frame - 1'b1;
                    end
                end
            end
            MODE_ONCE: begin
                if (r_cur_frame >= LAST_FRAME) begin
                    w_step_frame = LAST_FRAME;
                    w_step_last  = 1'b1;
                end else begin
                    w_step_frame = r_cur_frame + 1'b1;
                    w_step_last  = ((r_cur_frame + 1'b1) == LAST_FRAME);
                end
            end
            default: begin
                w_step_frame = r_cur_frame;
            end
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cur_nxt   = r_cur_frame;
        w_hold_nxt  = r_hold_cnt;
        w_dir_nxt   = r_dir;
        w_pend_nxt  = r_start_pend;
        w_done_nxt  = r_done;

        if (start) begin
            w_pend_nxt = 1'b1;
        end

        if (vsync) begin
            if (start || r_start_pend) begin
                w_pend_nxt  = 1'b0;
                w_cur_nxt   = w_sel_clamped;
                w_hold_nxt  = '0;
                w_dir_nxt   = 1'b1;
                w_done_nxt  = 1'b0;
                w_state_nxt = (mode == MODE_HOLD) ? ST_HOLD : ST_RUN;
            end else begin
                case (r_state)
                    ST_RUN: begin
                        if (mode == MODE_HOLD) begin
                            w_state_nxt = ST_HOLD;
                        end else if (w_hold_inc >= w_hold_lim) begin
                            w_hold_nxt = '0;
                            w_cur_nxt  = w_step_frame;
                            w_dir_nxt  = w_step_dir;
                            if (w_step_last) begin
                                w_state_nxt = ST_DONE;
                                w_done_nxt  = 1'b1;
                            end
                        end else begin
                            w_hold_nxt = w_hold_inc[HOLD_W-1:0];
                        end
                    end
                    default: begin
                        w_state_nxt = r_state;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_HOLD;
            r_cur_frame  <= '0;
            r_hold_cnt   <= '0;
            r_dir        <= 1'b1;
            r_start_pend <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cur_frame  <= w_cur_nxt;
            r_hold_cnt   <= w_hold_nxt;
            r_dir        <= w_dir_nxt;
            r_start_pend <= w_pend_nxt;
            r_done       <= w_done_nxt;
        end
    end

    assign cur_frame = r_cur_frame;
    assign done      = r_done;
    assign dbg_state = r_state;

`ifdef VRAM_FRAME_TICK_EN
    logic r_frame_tick;

    // High for the cycle that immediately follows a real change of frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= (w_cur_nxt != r_cur_frame);
        end
    end

    assign frame_tick = r_frame_tick;
`endif

endmodule

// File: tb/tb_vram_frame_player.sv
// Directed bench for vram_frame_player: read latency, blanking, animation modes,
// read-first collision and asynchronous reset.
module tb_vram_frame_player;

    localparam int ADDR_W     = 14;
    localparam int COLOR_W    = 1;
    localparam int NUM_FRAMES = 4;
    localparam int FRAME_W    = 2;
    localparam int HOLD_W     = 8;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [ADDR_W-1:0]    address;
    logic                 vsync;
    logic                 we;
    logic [FRAME_W-1:0]   wr_frame;
    logic [ADDR_W-1:0]    wr_addr;
    logic [3*COLOR_W-1:0] wr_data;
    logic [1:0]           mode;
    logic [HOLD_W-1:0]    hold_frames;
    logic [FRAME_W-1:0]   sel_frame;
    logic                 start;
    logic [COLOR_W-1:0]   red;
    logic [COLOR_W-1:0]   green;
    logic [COLOR_W-1:0]   blue;
    logic [FRAME_W-1:0]   cur_frame;
    logic                 done;
    logic [1:0]           dbg_state;
`ifdef VRAM_FRAME_TICK_EN
    logic                 frame_tick;
`endif

    logic [2:0] rgb;
    assign rgb = {red, green, blue};

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    vram_frame_player #(
        .ADDR_W     (ADDR_W),
        .COLOR_W    (COLOR_W),
        .NUM_FRAMES (NUM_FRAMES),
        .FRAME_W    (FRAME_W),
        .HOLD_W     (HOLD_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .address     (address),
        .vsync       (vsync),
        .we          (we),
        .wr_frame    (wr_frame),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .mode        (mode),
        .hold_frames (hold_frames),
        .sel_frame   (sel_frame),
        .start       (start),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .cur_frame   (cur_frame),
        .done        (done),
`ifdef VRAM_FRAME_TICK_EN
        .frame_tick  (frame_tick),
`endif
        .dbg_state   (dbg_state)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_vsync();
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
    endtask

    task automatic start_vsync(input logic [1:0] m, input logic [FRAME_W-1:0] f);
        mode      = m;
        sel_frame = f;
        start     = 1'b1;
        vsync     = 1'b1;
        tick();
        start     = 1'b0;
        vsync     = 1'b0;
    endtask

    task automatic write_px(input logic [FRAME_W-1:0] f, input logic [ADDR_W-1:0] a,
                            input logic [2:0] d);
        we       = 1'b1;
        wr_frame = f;
        wr_addr  = a;
        wr_data  = d;
        tick();
        we       = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [FRAME_W-1:0] exp_loop [8];
        logic [FRAME_W-1:0] exp_ping [7];
        logic [FRAME_W-1:0] prev;

        exp_loop = '{2'd3, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3};
        exp_ping = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0, 2'd1};

        reset       = 1'b1;
        address     = '0;
        vsync       = 1'b0;
        we          = 1'b0;
        wr_frame    = '0;
        wr_addr     = '0;
        wr_data     = '0;
        mode        = 2'b00;
        hold_frames = '0;
        sel_frame   = '0;
        start       = 1'b0;

        // Reset state
        #2;
        chk("reset_rgb", rgb, 3'b000);
        chk("reset_cur", cur_frame, 2'd0);
        chk("reset_done", done, 1'b0);
        chk("reset_state", dbg_state, 2'd0);
        tick();
        tick();
        reset = 1'b0;

        // Preload
        for (int k = 0; k < NUM_FRAMES; k++) begin
            write_px(FRAME_W'(k), 14'd5, 3'(k + 1));
        end
        write_px(2'd0, 14'h3FFF, 3'b111);
        write_px(2'd0, 14'd0, 3'b101);
        write_px(2'd0, 14'd7, 3'b000);

        // Hold mode: start waits for vsync, then frame 2 pixel 5 shows
        mode      = 2'b00;
        sel_frame = 2'd2;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        chk("pend_cur0", cur_frame, 2'd0);
        tick();
        tick();
        chk("pend_cur1", cur_frame, 2'd0);
        pulse_vsync();
        chk("hold_cur", cur_frame, 2'd2);
        chk("hold_state", dbg_state, 2'd0);
        address = 14'd5;
        tick();
        tick();
        tick();
        chk("hold_rgb", rgb, 3'b011);
        pulse_vsync();
        chk("hold_stays", cur_frame, 2'd2);

        // Blank address, then address 0 of frame 0
        start_vsync(2'b00, 2'd0);
        chk("blank_cur", cur_frame, 2'd0);
        address = 14'h3FFF;
        tick();
        address = 14'd0;
        tick();
        tick();
        chk("blank_rgb", rgb, 3'b000);
        tick();
        chk("after_blank_rgb", rgb, 3'b101);

        // Loop, hold_frames=2, from frame 3
        hold_frames = 8'd2;
        start_vsync(2'b01, 2'd3);
        chk("loop_start", cur_frame, 2'd3);
        chk("loop_state", dbg_state, 2'd1);
        prev = cur_frame;
        for (int i = 0; i < 8; i++) begin
            tick();
            tick();
            pulse_vsync();
            chk($sformatf("loop_v%0d", i), cur_frame, exp_loop[i]);
`ifdef VRAM_FRAME_TICK_EN
            chk($sformatf("loop_tick%0d", i), frame_tick, exp_loop[i] != prev);
`endif
            prev = exp_loop[i];
        end

        // Ping-pong, hold_frames=0 behaves as 1
        hold_frames = 8'd0;
        start_vsync(2'b10, 2'd0);
        chk("ping_start", cur_frame, 2'd0);
        for (int i = 0; i < 7; i++) begin
            tick();
            pulse_vsync();
            chk($sformatf("ping_v%0d", i), cur_frame, exp_ping[i]);
        end

        // One-shot from frame 1
        hold_frames = 8'd1;
        start_vsync(2'b11, 2'd1);
        chk("once_start", cur_frame, 2'd1);
        chk("once_done0", done, 1'b0);
        pulse_vsync();
        chk("once_cur2", cur_frame, 2'd2);
        chk("once_done_early", done, 1'b0);
        pulse_vsync();
        chk("once_cur3", cur_frame, 2'd3);
        chk("once_done", done, 1'b1);
        chk("once_state", dbg_state, 2'd2);
        pulse_vsync();
        pulse_vsync();
        chk("once_frozen", cur_frame, 2'd3);
        chk("once_done_held", done, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("once_done_pend", done, 1'b1);
        pulse_vsync();
        chk("restart_done", done, 1'b0);
        chk("restart_cur", cur_frame, 2'd1);
        chk("restart_state", dbg_state, 2'd1);
        mode = 2'b00;
        pulse_vsync();
        chk("run_to_hold_cur", cur_frame, 2'd1);
        chk("run_to_hold_state", dbg_state, 2'd0);

        // Read-first collision at frame 0 address 7
        start_vsync(2'b00, 2'd0);
        chk("coll_cur", cur_frame, 2'd0);
        address  = 14'd7;
        we       = 1'b1;
        wr_frame = 2'd0;
        wr_addr  = 14'd7;
        wr_data  = 3'b111;
        tick();
        we = 1'b0;
        tick();
        tick();
        chk("coll_old", rgb, 3'b000);
        tick();
        chk("coll_new", rgb, 3'b111);

        // Reset in the middle of a running loop
        hold_frames = 8'd1;
        start_vsync(2'b01, 2'd2);
        address = 14'd5;
        tick();
        tick();
        tick();
        chk("prerst_rgb", rgb, 3'b011);
        chk("prerst_cur", cur_frame, 2'd2);
        chk("prerst_state", dbg_state, 2'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_rgb", rgb, 3'b000);
        chk("rst_cur", cur_frame, 2'd0);
        chk("rst_done", done, 1'b0);
        chk("rst_state", dbg_state, 2'd0);
        tick();
        reset = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
